// File: rtl/tcm_port_arbiter_if.sv
// Request/response and RAM-side signal bundle for one TCM port arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface tcm_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      ifu_req_valid;
    logic                      ifu_req_ready;
    logic [ADDR_WIDTH-1:0]     ifu_req_addr;
    logic                      ifu_rsp_valid;
    logic [DATA_WIDTH-1:0]     ifu_rsp_rdata;

    logic                      lsu_req_valid;
    logic                      lsu_req_ready;
    logic [ADDR_WIDTH-1:0]     lsu_req_addr;
    logic                      lsu_req_we;
    logic [DATA_WIDTH-1:0]     lsu_req_wdata;
    logic [DATA_WIDTH/8-1:0]   lsu_req_wmask;
    logic                      lsu_rsp_valid;
    logic [DATA_WIDTH-1:0]     lsu_rsp_rdata;

    logic                      ldr_active;
    logic                      ldr_req_valid;
    logic                      ldr_req_ready;
    logic [ADDR_WIDTH-1:0]     ldr_req_addr;
    logic [DATA_WIDTH-1:0]     ldr_req_wdata;

    logic                      ram_cs;
    logic                      ram_we;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [DATA_WIDTH/8-1:0]   ram_wem;
    logic [DATA_WIDTH-1:0]     ram_din;
    logic [DATA_WIDTH-1:0]     ram_dout;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata,
        input  lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        input  ldr_active, ldr_req_valid, ldr_req_addr, ldr_req_wdata,
        output ldr_req_ready,
        output ram_cs, ram_we, ram_addr, ram_wem, ram_din,
        input  ram_dout
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata,
        output lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        output ldr_active, ldr_req_valid, ldr_req_addr, ldr_req_wdata,
        input  ldr_req_ready,
        input  ram_cs, ram_we, ram_addr, ram_wem, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/tcm_port_arbiter.sv
// Single-port TCM arbiter: loader > LSU > IFU with IFU anti-starvation,
// one access per cycle and a registered owner tag routing the 1-cycle read data.
module tcm_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    tcm_port_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_IFU,
        OWN_LSU_RD,
        OWN_LSU_WR,
        OWN_LDR
    } own_e;

    own_e       rsp_own, rsp_own_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       force_ifu;
    logic       ifu_gnt, lsu_gnt, ldr_gnt;

    // Grants are gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        force_ifu = (starve_cnt == LIMIT) && bus.ifu_req_valid && !bus.ldr_active;
        ldr_gnt   = rst_n && bus.ldr_active && bus.ldr_req_valid;
        lsu_gnt   = rst_n && !bus.ldr_active && bus.lsu_req_valid && !force_ifu;
        ifu_gnt   = rst_n && !bus.ldr_active && bus.ifu_req_valid
                    && (force_ifu || !bus.lsu_req_valid);
    end

    assign bus.ldr_req_ready = ldr_gnt;
    assign bus.lsu_req_ready = lsu_gnt;
    assign bus.ifu_req_ready = ifu_gnt;

    always_comb begin
        bus.ram_cs   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_wem  = '0;
        bus.ram_din  = '0;
        if (ldr_gnt) begin
            bus.ram_cs   = 1'b1;
            bus.ram_we   = 1'b1;
            bus.ram_addr = bus.ldr_req_addr;
            bus.ram_wem  = '1;
            bus.ram_din  = bus.ldr_req_wdata;
        end else if (lsu_gnt) begin
            bus.ram_cs   = 1'b1;
            bus.ram_we   = bus.lsu_req_we;
            bus.ram_addr = bus.lsu_req_addr;
            bus.ram_wem  = bus.lsu_req_we ? bus.lsu_req_wmask : '0;
            bus.ram_din  = bus.lsu_req_wdata;
        end else if (ifu_gnt) begin
            bus.ram_cs   = 1'b1;
            bus.ram_addr = bus.ifu_req_addr;
        end
    end

    always_comb begin
        rsp_own_nxt    = OWN_NONE;
        starve_cnt_nxt = starve_cnt;
        if (ldr_gnt)      rsp_own_nxt = OWN_LDR;
        else if (lsu_gnt) rsp_own_nxt = bus.lsu_req_we ? OWN_LSU_WR : OWN_LSU_RD;
        else if (ifu_gnt) rsp_own_nxt = OWN_IFU;

        // Count only LSU wins taken while IFU was waiting; saturate at the limit.
        if (ifu_gnt || !bus.ifu_req_valid)
            starve_cnt_nxt = '0;
        else if (lsu_gnt && starve_cnt != LIMIT)
            starve_cnt_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_own    <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            rsp_own    <= rsp_own_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign bus.ifu_rsp_valid = (rsp_own == OWN_IFU);
    assign bus.ifu_rsp_rdata = (rsp_own == OWN_IFU) ? bus.ram_dout : '0;
    assign bus.lsu_rsp_valid = (rsp_own == OWN_LSU_RD) || (rsp_own == OWN_LSU_WR);
    assign bus.lsu_rsp_rdata = (rsp_own == OWN_LSU_RD) ? bus.ram_dout : '0;
endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: directed vector table, random traffic against a
// behavioural model with its own memory image, and a reset-during-read sequence.
module tb_tcm_port_arbiter;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int MW    = DW / 8;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tcm_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    tcm_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Environment RAM: 1-cycle read latency, byte write mask.
    logic [DW-1:0] ram [0:63] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) begin
                for (int b = 0; b < MW; b++)
                    if (bus.ram_wem[b]) ram[bus.ram_addr[5:0]][b*8 +: 8] <= bus.ram_din[b*8 +: 8];
            end else begin
                bus.ram_dout <= ram[bus.ram_addr[5:0]];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] mem [0:63] = '{default: '0};
    int            streak;
    logic          pend_ifu_v, pend_lsu_v;
    logic [DW-1:0] pend_ifu_d, pend_lsu_d;
    int            n_checks;
    int            n_fail;

    typedef struct {
        logic          la, lv, sv, swe, iv;
        logic [AW-1:0] ldr_addr;
        logic [DW-1:0] ldr_wdata;
        logic [AW-1:0] lsu_addr;
        logic [DW-1:0] lsu_wdata;
        logic [MW-1:0] lsu_mask;
        logic [AW-1:0] ifu_addr;
        int            gnt;   // 0 none, 1 IFU, 2 LSU, 3 LDR
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic la, lv, sv, swe, iv,
                                input int ldr_a, input logic [DW-1:0] ldr_d,
                                input int lsu_a, input logic [DW-1:0] lsu_d,
                                input logic [MW-1:0] mask, input int ifu_a, input int gnt);
        vec_t v;
        v.la = la; v.lv = lv; v.sv = sv; v.swe = swe; v.iv = iv;
        v.ldr_addr = AW'(ldr_a); v.ldr_wdata = ldr_d;
        v.lsu_addr = AW'(lsu_a); v.lsu_wdata = lsu_d; v.lsu_mask = mask;
        v.ifu_addr = AW'(ifu_a); v.gnt = gnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.ldr_active    = v.la;
        bus.ldr_req_valid = v.lv;
        bus.ldr_req_addr  = v.ldr_addr;
        bus.ldr_req_wdata = v.ldr_wdata;
        bus.lsu_req_valid = v.sv;
        bus.lsu_req_we    = v.swe;
        bus.lsu_req_addr  = v.lsu_addr;
        bus.lsu_req_wdata = v.lsu_wdata;
        bus.lsu_req_wmask = v.lsu_mask;
        bus.ifu_req_valid = v.iv;
        bus.ifu_req_addr  = v.ifu_addr;
    endtask

    // Called just after a falling edge with inputs applied; checks, advances the model,
    // and returns at the next falling edge.
    task automatic cycle(input int tab_gnt, output int mg);
        logic [DW-1:0] m;
        int            ag;
        #1;
        mg = 0;
        if (rst_n) begin
            if (bus.ldr_active)                           mg = bus.ldr_req_valid ? 3 : 0;
            else if (bus.ifu_req_valid && streak >= LIMIT) mg = 1;
            else if (bus.lsu_req_valid)                   mg = 2;
            else if (bus.ifu_req_valid)                   mg = 1;
        end else begin
            pend_ifu_v = 1'b0;
            pend_lsu_v = 1'b0;
        end

        chk("ifu_req_ready", bus.ifu_req_ready, mg == 1);
        chk("lsu_req_ready", bus.lsu_req_ready, mg == 2);
        chk("ldr_req_ready", bus.ldr_req_ready, mg == 3);
        chk("ram_cs", bus.ram_cs, mg != 0);
        if (mg == 3) begin
            chk("ram_we_ldr", bus.ram_we, 1'b1);
            chk("ram_addr_ldr", bus.ram_addr, bus.ldr_req_addr);
            chk("ram_wem_ldr", bus.ram_wem, {MW{1'b1}});
            chk("ram_din_ldr", bus.ram_din, bus.ldr_req_wdata);
        end else if (mg == 2) begin
            chk("ram_we_lsu", bus.ram_we, bus.lsu_req_we);
            chk("ram_addr_lsu", bus.ram_addr, bus.lsu_req_addr);
            if (bus.lsu_req_we) begin
                chk("ram_wem_lsu", bus.ram_wem, bus.lsu_req_wmask);
                chk("ram_din_lsu", bus.ram_din, bus.lsu_req_wdata);
            end
        end else if (mg == 1) begin
            chk("ram_we_ifu", bus.ram_we, 1'b0);
            chk("ram_addr_ifu", bus.ram_addr, bus.ifu_req_addr);
            chk("ram_wem_ifu", bus.ram_wem, '0);
        end else begin
            chk("ram_we_idle", bus.ram_we, 1'b0);
        end

        chk("ifu_rsp_valid", bus.ifu_rsp_valid, pend_ifu_v);
        chk("ifu_rsp_rdata", bus.ifu_rsp_rdata, pend_ifu_v ? pend_ifu_d : '0);
        chk("lsu_rsp_valid", bus.lsu_rsp_valid, pend_lsu_v);
        chk("lsu_rsp_rdata", bus.lsu_rsp_rdata, pend_lsu_v ? pend_lsu_d : '0);

        if (tab_gnt >= 0) begin
            ag = bus.ldr_req_ready ? 3 : bus.lsu_req_ready ? 2 : bus.ifu_req_ready ? 1 : 0;
            chk("table_grant", ag, tab_gnt);
        end

        pend_ifu_v = 1'b0;
        pend_lsu_v = 1'b0;
        case (mg)
            1: begin
                pend_ifu_v = 1'b1;
                pend_ifu_d = mem[bus.ifu_req_addr[5:0]];
            end
            2: begin
                pend_lsu_v = 1'b1;
                if (bus.lsu_req_we) begin
                    for (int b = 0; b < MW; b++)
                        m[b*8 +: 8] = {8{bus.lsu_req_wmask[b]}};
                    mem[bus.lsu_req_addr[5:0]] = (mem[bus.lsu_req_addr[5:0]] & ~m)
                                               | (bus.lsu_req_wdata & m);
                    pend_lsu_d = '0;
                end else begin
                    pend_lsu_d = mem[bus.lsu_req_addr[5:0]];
                end
            end
            3: mem[bus.ldr_req_addr[5:0]] = bus.ldr_req_wdata;
            default: ;
        endcase

        if (!rst_n || mg == 1 || !bus.ifu_req_valid) streak = 0;
        else if (mg == 2 && streak < LIMIT)          streak++;

        @(negedge clk);
    endtask

    initial begin
        int mg;
        int last;
        n_checks   = 0;
        n_fail     = 0;
        streak     = 0;
        pend_ifu_v = 1'b0;
        pend_lsu_v = 1'b0;
        pend_ifu_d = '0;
        pend_lsu_d = '0;

        vecs.push_back(mk(0,1,1,0,1, 0, 32'h0,          0, 32'h0,          4'h0, 1, 2));
        vecs.push_back(mk(1,1,1,0,1, 0, 32'h00000013,   0, 32'h0,          4'h0, 1, 3));
        vecs.push_back(mk(1,1,1,0,1, 1, 32'h00100093,   0, 32'h0,          4'h0, 1, 3));
        vecs.push_back(mk(1,1,1,0,1, 2, 32'h00200113,   0, 32'h0,          4'h0, 1, 3));
        vecs.push_back(mk(1,1,1,0,1, 3, 32'h002081B3,   0, 32'h0,          4'h0, 1, 3));
        vecs.push_back(mk(1,1,1,0,1, 5, 32'hCAFEF00D,   0, 32'h0,          4'h0, 1, 3));
        vecs.push_back(mk(0,0,0,0,1, 0, 32'h0,          0, 32'h0,          4'h0, 1, 1));
        vecs.push_back(mk(0,0,0,0,0, 0, 32'h0,          0, 32'h0,          4'h0, 0, 0));
        vecs.push_back(mk(0,0,1,1,0, 0, 32'h0,          5, 32'hDEADBEEF,   4'h3, 0, 2));
        vecs.push_back(mk(0,0,1,0,0, 0, 32'h0,          5, 32'h0,          4'h0, 0, 2));
        vecs.push_back(mk(0,0,0,0,0, 0, 32'h0,          0, 32'h0,          4'h0, 0, 0));
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < LIMIT; k++)
                vecs.push_back(mk(0,0,1,0,1, 0, 32'h0, 3, 32'h0, 4'h0, 2, 2));
            vecs.push_back(mk(0,0,1,0,1, 0, 32'h0, 3, 32'h0, 4'h0, 2, 1));
        end
        vecs.push_back(mk(0,0,0,0,0, 0, 32'h0,          0, 32'h0,          4'h0, 0, 0));

        // Reset held with every requester valid
        rst_n = 1'b0;
        apply(mk(0,1,1,0,1, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0));
        @(negedge clk);
        cycle(0, mg);
        cycle(0, mg);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            cycle(vecs[i].gnt, mg);
        end
        chk("ram5_merged", mem[5], 32'hCAFEBEEF);

        // Random traffic; a request not granted is held unchanged
        last = 0;
        bus.ldr_active = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!bus.ifu_req_valid || last == 1) begin
                bus.ifu_req_valid = ($urandom_range(0, 99) < 70);
                bus.ifu_req_addr  = AW'($urandom_range(0, 15));
            end
            if (!bus.lsu_req_valid || last == 2) begin
                bus.lsu_req_valid = ($urandom_range(0, 99) < 60);
                bus.lsu_req_we    = $urandom_range(0, 1) == 1;
                bus.lsu_req_addr  = AW'($urandom_range(0, 15));
                bus.lsu_req_wdata = $urandom;
                bus.lsu_req_wmask = MW'($urandom_range(0, 15));
            end
            if (!bus.ldr_req_valid || last == 3) begin
                bus.ldr_req_valid = $urandom_range(0, 1) == 1;
                bus.ldr_req_addr  = AW'($urandom_range(0, 15));
                bus.ldr_req_wdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) bus.ldr_active = ~bus.ldr_active;
            cycle(-1, mg);
            last = mg;
        end

        // Reset asserted in the cycle after an IFU read grant
        apply(mk(0,0,0,0,1, 0, 32'h0, 0, 32'h0, 4'h0, 2, 0));
        cycle(1, mg);
        apply(mk(0,0,0,0,1, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0));
        #1;
        chk("pre_rst_ifu_ready", bus.ifu_req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ifu_rsp_valid", bus.ifu_rsp_valid, 1'b0);
        chk("rst_ifu_rsp_rdata", bus.ifu_rsp_rdata, '0);
        chk("rst_ifu_req_ready", bus.ifu_req_ready, 1'b0);
        chk("rst_ram_cs", bus.ram_cs, 1'b0);
        pend_ifu_v = 1'b0;
        pend_lsu_v = 1'b0;
        streak     = 0;
        @(negedge clk);
        cycle(0, mg);
        rst_n = 1'b1;
        cycle(1, mg);
        apply(mk(0,0,0,0,0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0));
        cycle(0, mg);
        cycle(0, mg);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
